// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the fetch/data memory port arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port; ARB_ROUND_ROBIN_EN picks round-robin, else data priority.
// gnt one cycle after request, valid WAIT_STATES+2 cycles after; a losing request stays pending until granted.
module mem_port_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              sel_d, sel_d_nxt;
   logic              start;
   logic              pick_d;
   logic              last_cycle;

   logic              if_gnt_q, if_valid_q, d_gnt_q, d_valid_q;
   logic              mem_en_q, mem_we_q, busy_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic              last_d;
`endif

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      sel_d_nxt  = sel_d;
      start      = 1'b0;
      last_cycle = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      // On contention the requester that was not served last wins.
      pick_d     = bus.d_req && !(bus.if_req && last_d);
`else
      pick_d     = bus.d_req;
`endif
      case (state)
         IDLE, DONE: begin
            if (bus.if_req || bus.d_req) begin
               state_nxt = ACCESS;
               cnt_nxt   = 4'd0;
               sel_d_nxt = pick_d;
               start     = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         ACCESS: begin
            if (cnt == LAST_CNT) begin
               state_nxt  = DONE;
               last_cycle = 1'b1;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         sel_d <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sel_d <= sel_d_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         if_gnt_q   <= start && !pick_d;
         d_gnt_q    <= start && pick_d;
         if_valid_q <= last_cycle && !sel_d;
         d_valid_q  <= last_cycle && sel_d;
         busy_q     <= (state_nxt != IDLE);
         // Memory bus is frozen for the whole access; fetches never write.
         if (start) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= pick_d && bus.d_we;
            mem_addr_q  <= pick_d ? bus.d_addr : bus.if_addr;
            mem_wdata_q <= pick_d ? bus.d_wdata : '0;
         end else if (last_cycle) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
         end
         if (last_cycle && !sel_d) begin
            if_rdata_q <= bus.mem_rdata;
         end
         if (last_cycle && sel_d && !mem_we_q) begin
            d_rdata_q <= bus.mem_rdata;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_d <= 1'b0;
      end else if (start) begin
         last_d <= pick_d;
      end
   end
`endif

   assign bus.if_gnt    = if_gnt_q;
   assign bus.d_gnt     = d_gnt_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed spec scenarios plus random traffic against a transaction-timeline model.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int WS = 1;
   localparam int NC = 4096;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut_ws0 (
      .clk(clk), .reset_n(reset_n), .bus(bus1));

   function automatic logic [15:0] pat(input int i);
      if (i == 64) return 16'hBEEF;
      return 16'(i * 257) ^ 16'h3C5A;
   endfunction

   // Shared memory model: loaded with pat() once, written by the WS=1 instance.
   logic [DW-1:0] mem_array [256];
   logic          mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem_array[i] <= pat(i);
         mem_loaded <= 1'b1;
      end else if (bus.mem_en && bus.mem_we) begin
         mem_array[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata  = mem_array[bus.mem_addr[7:0]];
   assign bus1.mem_rdata = mem_array[bus1.mem_addr[7:0]];

   // Expected per-cycle events, filled in when the model decides a grant.
   bit          e_ig[NC], e_dg[NC], e_iv[NC], e_dv[NC], e_dupd[NC], e_rst[NC];
   bit          e_busy[NC], e_men[NC], e_mwe[NC], e_wchk[NC];
   logic [15:0] e_maddr[NC], e_mwd[NC], e_idat[NC], e_ddat[NC];
   logic [15:0] ref_mem[256];
   logic [15:0] cur_i, cur_d;
   int          cyc, free_cyc;
   bit          last_d, gr_i, gr_d, pend_i, pend_d;
   int          checks, errors;
   logic [7:0]  got[4];
   int          ng, nv1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic clear_slot(input int i);
      e_ig[i] = 0; e_dg[i] = 0; e_iv[i] = 0; e_dv[i] = 0; e_dupd[i] = 0; e_rst[i] = 0;
      e_busy[i] = 0; e_men[i] = 0; e_mwe[i] = 0; e_wchk[i] = 0;
   endtask

   // Check the current cycle, then let the model react to this cycle's inputs.
   task automatic step();
      int  g, v, a;
      bit  pd;
      @(negedge clk);
      if (e_rst[cyc]) begin cur_i = '0; cur_d = '0; end
      if (e_iv[cyc]) cur_i = e_idat[cyc];
      if (e_dv[cyc] && e_dupd[cyc]) cur_d = e_ddat[cyc];
      chk("if_gnt", bus.if_gnt, e_ig[cyc]);
      chk("d_gnt", bus.d_gnt, e_dg[cyc]);
      chk("if_valid", bus.if_valid, e_iv[cyc]);
      chk("d_valid", bus.d_valid, e_dv[cyc]);
      chk("busy", bus.busy, e_busy[cyc]);
      chk("mem_en", bus.mem_en, e_men[cyc]);
      chk("if_rdata", bus.if_rdata, cur_i);
      chk("d_rdata", bus.d_rdata, cur_d);
      if (e_men[cyc]) begin
         chk("mem_addr", bus.mem_addr, e_maddr[cyc]);
         chk("mem_we", bus.mem_we, e_mwe[cyc]);
         if (e_wchk[cyc]) chk("mem_wdata", bus.mem_wdata, e_mwd[cyc]);
      end
      gr_i = 0;
      gr_d = 0;
      if (!reset_n) begin
         for (int k = 1; k <= WS + 3; k++) clear_slot(cyc + k);
         e_rst[cyc+1] = 1;
         free_cyc = cyc + 1;
         last_d = 0;
      end else if (cyc >= free_cyc && (bus.if_req || bus.d_req)) begin
         if (bus.if_req && bus.d_req) pd = RR ? !last_d : 1'b1;
         else pd = bus.d_req;
         g = cyc + 1;
         v = g + WS + 1;
         a = pd ? int'(bus.d_addr[7:0]) : int'(bus.if_addr[7:0]);
         for (int k = 0; k <= WS; k++) begin
            e_men[g+k]   = 1;
            e_maddr[g+k] = pd ? bus.d_addr : bus.if_addr;
            e_mwe[g+k]   = pd && bus.d_we;
            e_wchk[g+k]  = pd;
            e_mwd[g+k]   = bus.d_wdata;
         end
         for (int k = 0; k <= WS + 1; k++) e_busy[g+k] = 1;
         if (pd) begin
            e_dg[g] = 1;
            e_dv[v] = 1;
            if (!bus.d_we) begin
               e_dupd[v] = 1;
               e_ddat[v] = ref_mem[a];
            end else begin
               ref_mem[a] = bus.d_wdata;
            end
            gr_d = 1;
         end else begin
            e_ig[g] = 1;
            e_iv[v] = 1;
            e_idat[v] = ref_mem[a];
            gr_i = 1;
         end
         free_cyc = v;
         last_d = pd;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      checks = 0; errors = 0; cur_i = '0; cur_d = '0; last_d = 0;
      pend_i = 0; pend_d = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
      reset_n = 0;
      @(posedge clk);
      #1;
      cyc = 0;
      free_cyc = 0;
      repeat (3) step();
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_ws0_busy", bus1.busy, 0);
      reset_n = 1;
      repeat (2) step();

      // Single load of 0x0040.
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0040; bus.d_wdata = 16'h0;
      step();
      chk("ld_gnt", bus.d_gnt, 1);
      chk("ld_en_1", bus.mem_en, 1);
      step();
      chk("ld_en_2", bus.mem_en, 1);
      chk("ld_early_valid", bus.d_valid, 0);
      bus.d_req = 0;
      step();
      chk("ld_valid", bus.d_valid, 1);
      chk("ld_rdata", bus.d_rdata, 16'hBEEF);
      chk("ld_en_done", bus.mem_en, 0);
      step();

      // Single store to 0x0010.
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0010; bus.d_wdata = 16'h1234;
      step();
      chk("st_we_1", bus.mem_we, 1);
      chk("st_wdata_1", bus.mem_wdata, 16'h1234);
      bus.d_req = 0; bus.d_we = 0;
      step();
      chk("st_we_2", bus.mem_we, 1);
      chk("st_wdata_2", bus.mem_wdata, 16'h1234);
      step();
      chk("st_valid", bus.d_valid, 1);
      chk("st_rdata_kept", bus.d_rdata, 16'hBEEF);
      step();

      // Contention after a fresh reset.
      reset_n = 0;
      step();
      reset_n = 1;
      bus.if_req = 1; bus.if_addr = 16'h0020; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0021;
      ng = 0;
      for (int i = 0; i < 4; i++) got[i] = "-";
      for (int k = 0; k < 16 && ng < 4; k++) begin
         step();
         if (bus.d_gnt) begin got[ng] = "D"; ng++; end
         else if (bus.if_gnt) begin got[ng] = "I"; ng++; end
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("contend_%0d", i), got[i], (RR && (i % 2 == 1)) ? "I" : "D");
      bus.if_req = 0; bus.d_req = 0;
      repeat (5) step();

      // Reset asserted during the second access cycle of a load.
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0005;
      step();
      step();
      reset_n = 0; bus.d_req = 0;
      step();
      chk("abort_valid", bus.d_valid, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_mem_en", bus.mem_en, 0);
      chk("abort_mem_addr", bus.mem_addr, 0);
      reset_n = 1;
      repeat (3) step();
      bus.d_req = 1; bus.d_addr = 16'h0007;
      step();
      bus.d_req = 0;
      step();
      step();
      chk("fresh_valid", bus.d_valid, 1);
      chk("fresh_rdata", bus.d_rdata, ref_mem[7]);
      step();

      // Random traffic from both requesters.
      gr_i = 0; gr_d = 0;
      for (int n = 0; n < 800; n++) begin
         if (gr_i) pend_i = 0;
         if (gr_d) pend_d = 0;
         if (pend_i && $urandom_range(0, 99) < 3) pend_i = 0;
         if (pend_d && $urandom_range(0, 99) < 3) pend_d = 0;
         if (!pend_i) begin
            bus.if_addr = 16'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 35) pend_i = 1;
         end
         if (!pend_d) begin
            bus.d_addr  = 16'($urandom_range(0, 31));
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_wdata = 16'($urandom);
            if ($urandom_range(0, 99) < 35) pend_d = 1;
         end
         bus.if_req = pend_i;
         bus.d_req  = pend_d;
         step();
      end
      bus.if_req = 0; bus.d_req = 0;
      repeat (6) step();

      // Zero wait states: continuous fetch on the second instance.
      bus1.if_addr = 16'h0003;
      bus1.if_req = 1;
      nv1 = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ws0_gnt_%0d", k), bus1.if_gnt, (k % 2 == 1));
         chk($sformatf("ws0_men_%0d", k), bus1.mem_en, (k % 2 == 1));
         chk($sformatf("ws0_valid_%0d", k), bus1.if_valid, (k % 2 == 0));
         if (bus1.if_valid) nv1++;
         if (k % 2 == 0) chk($sformatf("ws0_rdata_%0d", k), bus1.if_rdata, ref_mem[3]);
      end
      chk("ws0_valid_count", nv1, 6);
      bus1.if_req = 0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, 16, data width.
REQ-003 Parameter WAIT_STATES, 1, extra memory cycles per access; legal range 0..15.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch read request; held until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch address; stable while if_req high.
REQ-008 if_gnt  out  1  one-cycle pulse: fetch accepted.
REQ-009 if_valid  out  1  one-cycle pulse: if_rdata valid.
REQ-010 if_rdata  out  DATA_W  fetch read data, held until next fetch completes.
REQ-011 d_req  in  1  data load/store request; held until d_gnt.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_gnt  out  1  one-cycle pulse: data access accepted.
REQ-016 d_valid  out  1  one-cycle pulse: load data valid or store complete.
REQ-017 d_rdata  out  DATA_W  load data, held until next load completes.
REQ-018 mem_en / mem_we  out  1 each  memory enable / write enable.
REQ-019 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write data.
REQ-020 mem_rdata  in  DATA_W  memory read data, valid on final ACCESS cycle.
REQ-021 busy  out  1  high whenever state is not IDLE.

Function
REQ-022 FSM states IDLE, ACCESS, DONE; all outputs registered.
REQ-023 IDLE or DONE with any request pending -> ACCESS next cycle; no request -> IDLE.
REQ-024 On entry to ACCESS: winner's address, we, wdata latched onto mem_* outputs; winner's gnt pulses in first ACCESS cycle.
REQ-025 ACCESS lasts exactly WAIT_STATES+1 cycles, tracked by a 4-bit counter; mem_en high, mem_addr/mem_we/mem_wdata constant throughout.
REQ-026 Fetch accesses drive mem_we=0 regardless of d_we.
REQ-027 Final ACCESS edge captures mem_rdata into winner's rdata register (loads and fetches only); stores leave d_rdata unchanged.
REQ-028 DONE lasts one cycle: mem_en=0, winner's valid pulses.
REQ-029 Latency: request seen at cycle N in IDLE -> gnt at N+1, valid at N+2+WAIT_STATES; back-to-back accesses via DONE->ACCESS, no IDLE bubble.
REQ-030 Contention (both req in same arbitration cycle): resolved per REQ-034/035; loser stays pending, no gnt.
REQ-031 Requests dropped before gnt are ignored without error; requests changing during ACCESS have no effect on the current access.

Reset
REQ-032 reset_n low at posedge: state IDLE, counter 0, last-grant flag = fetch, all gnt/valid/mem_en/mem_we/busy 0, mem_addr/mem_wdata/if_rdata/d_rdata 0.
REQ-033 Reset during ACCESS or DONE aborts the access; no gnt or valid issued for it after reset release.

Configuration
REQ-034 ARB_ROUND_ROBIN_EN defined: on contention grant the requester not granted last (last-grant flag updated on every grant); first contention after reset goes to data.
REQ-035 ARB_ROUND_ROBIN_EN undefined: data always wins contention; last-grant flag absent.

Verification
REQ-036 WAIT_STATES=1, single load d_addr=0x0040, mem_rdata=0xBEEF -> d_gnt at N+1, mem_en 2 cycles, d_valid at N+3, d_rdata=0xBEEF.
REQ-037 Store d_addr=0x0010 d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 for 2 cycles, d_valid at N+3, d_rdata unchanged.
REQ-038 if_req and d_req both held 4 accesses -> without macro grants D,D,D,D (fetch starved); with macro D,I,D,I.
REQ-039 WAIT_STATES=0, continuous if_req -> if_valid every 2 cycles, mem_en never low for 2 consecutive cycles.
REQ-040 reset_n low during second ACCESS cycle -> next cycle all outputs 0, busy 0, no valid pulse; fresh request afterwards completes normally.
